// File: rtl/score_keeper.sv
// score_keeper
// Score and round-timer stage for one Duck Hunt match. Counts local hits,
// latches the opponent's score from the link, runs the round countdown and
// flags end of game. It also emits every change of the local score for
// transmission to the opponent.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   game_start         pulse: start/restart a round (highest priority)
//   duck_hit           pulse: local player hit a duck
//   tick_1s            pulse: one second elapsed
//   enemy_score_valid  strobe: enemy_score_in is valid
//   enemy_score_in     opponent score from the link receiver (7 bits)
//   my_score           local score (to comparator)
//   enemy_score        latched opponent score (to comparator)
//   time_left          seconds remaining in the round
//   game_active        high while a round is being played
//   game_over          high once the round has timed out
//   score_tx_valid     one-cycle pulse: score_tx_data must be sent
//   score_tx_data      local score to transmit
module score_keeper #(
  parameter int MAX_SCORE    = 99,
  parameter int GAME_SECONDS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       duck_hit,
  input  logic       tick_1s,
  input  logic       enemy_score_valid,
  input  logic [6:0] enemy_score_in,
  output logic [6:0] my_score,
  output logic [6:0] enemy_score,
  output logic [6:0] time_left,
  output logic       game_active,
  output logic       game_over,
  output logic       score_tx_valid,
  output logic [6:0] score_tx_data
);

  localparam logic [6:0] MAX7 = 7'(MAX_SCORE);
  localparam logic [6:0] GS7  = 7'(GAME_SECONDS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FINAL} state_t;

  state_t     state_q, state_d;
  logic [6:0] my_q, my_d;
  logic [6:0] en_q, en_d;
  logic [6:0] tl_q, tl_d;
  logic [6:0] txd_q, txd_d;
  logic       txv_q, txv_d;
  logic       act_q, act_d;
  logic       ovr_q, ovr_d;

  // Clamp an incoming opponent score to the local ceiling.
  function automatic logic [6:0] sat_score(input logic [6:0] v);
    return (v > MAX7) ? MAX7 : v;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (game_start) state_d = S_PLAY;
      S_PLAY: begin
        if (game_start) begin
          state_d = S_PLAY;
        end else if (tick_1s && (tl_q == 7'd1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: if (game_start) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status flags follow the next state so they are registered
  // and change together with the scores/timer.
  always_comb begin
    act_d = (state_d == S_PLAY);
    ovr_d = (state_d == S_FINAL);
  end

  // Score, timer and transmit datapath
  always_comb begin
    my_d  = my_q;
    en_d  = en_q;
    tl_d  = tl_q;
    txd_d = txd_q;
    txv_d = 1'b0;
    if (game_start) begin
      // A (re)start wins over everything else arriving in the same cycle.
      my_d  = 7'd0;
      en_d  = 7'd0;
      tl_d  = GS7;
      txv_d = 1'b1;
      txd_d = 7'd0;
    end else begin
      if (state_q == S_PLAY) begin
        // Compare before incrementing so the score can never wrap; a hit at
        // the ceiling is not a change and sends nothing.
        if (duck_hit && (my_q < MAX7)) begin
          my_d  = my_q + 7'd1;
          txv_d = 1'b1;
          txd_d = my_q + 7'd1;
        end
        if (tick_1s && (tl_q != 7'd0)) begin
          tl_d = tl_q - 7'd1;
        end
      end
      // A late final packet from the opponent is still taken after timeout.
      if ((state_q != S_IDLE) && enemy_score_valid) begin
        en_d = sat_score(enemy_score_in);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      my_q  <= 7'd0;
      en_q  <= 7'd0;
      tl_q  <= 7'd0;
      txd_q <= 7'd0;
      txv_q <= 1'b0;
      act_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      my_q  <= my_d;
      en_q  <= en_d;
      tl_q  <= tl_d;
      txd_q <= txd_d;
      txv_q <= txv_d;
      act_q <= act_d;
      ovr_q <= ovr_d;
    end
  end

  assign my_score       = my_q;
  assign enemy_score    = en_q;
  assign time_left      = tl_q;
  assign game_active    = act_q;
  assign game_over      = ovr_q;
  assign score_tx_valid = txv_q;
  assign score_tx_data  = txd_q;

endmodule

// File: doc/score_keeper.md
# score_keeper

Sequential score and round-timer stage for one Duck Hunt match. It sits directly upstream of the combinational score comparator and drives its two 7-bit score inputs. It counts local duck hits, latches the opponent's score from the inter-board link, runs the round countdown, and flags end of game. It also emits the local score for transmission to the opponent.

## Interface
Parameters:
- MAX_SCORE, 99, saturation ceiling for both scores; legal range 1..127.
- GAME_SECONDS, 60, round length in `tick_1s` pulses; legal range 1..127.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- game_start  input  1  one-cycle pulse; starts or restarts a round.
- duck_hit  input  1  one-cycle pulse; the local player hit a duck.
- tick_1s  input  1  one-cycle pulse, once per second.
- enemy_score_valid  input  1  one-cycle strobe; `enemy_score_in` is valid.
- enemy_score_in  input  7  opponent's score from the link receiver.
- my_score  output  7  local score; feeds the comparator.
- enemy_score  output  7  latched opponent score; feeds the comparator.
- time_left  output  7  seconds remaining in the round.
- game_active  output  1  high while in PLAYING.
- game_over  output  1  high while in FINAL; the comparator result is final.
- score_tx_valid  output  1  one-cycle pulse; `score_tx_data` must be sent.
- score_tx_data  output  7  local score to transmit.

## Operation
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `rst_n`. All outputs are registered.
- Reset values: state IDLE; `my_score`, `enemy_score`, `time_left`, `score_tx_data` are 0; `game_active`, `game_over`, `score_tx_valid` are 0.
- IDLE:
  - Scores hold their current values.
  - `duck_hit`, `tick_1s` and `enemy_score_valid` are ignored.
  - `game_start` moves the block to PLAYING.
- Entering PLAYING from any state:
  - `my_score` and `enemy_score` are set to 0.
  - `time_left` is set to GAME_SECONDS.
  - `score_tx_valid` pulses with `score_tx_data` = 0.
- PLAYING:
  - `duck_hit` increments `my_score` by 1. The increment saturates at MAX_SCORE.
  - Every real change of `my_score` produces one `score_tx_valid` pulse carrying the new value. A hit that arrives while already saturated produces no pulse.
  - `tick_1s` decrements `time_left`.
  - A tick that arrives when `time_left` = 1 sets `time_left` to 0 and moves the block to FINAL.
  - `game_start` restarts the round. `game_start` has priority over every other input in the same cycle.
- FINAL:
  - `my_score` and `time_left` are frozen. `duck_hit` and `tick_1s` are ignored.
  - `enemy_score_valid` is still accepted, so a late final packet from the opponent is captured.
  - `game_start` moves the block to PLAYING.
- Enemy capture (PLAYING and FINAL only): on `enemy_score_valid`, `enemy_score` = min(`enemy_score_in`, MAX_SCORE).
- Simultaneous `duck_hit` and final `tick_1s` in one cycle: the hit counts and the transition to FINAL still occurs. The resulting `score_tx_valid` pulse is emitted normally.
- Arithmetic:
  - All counters are 7 bits.
  - The saturation compare happens before the increment, so `my_score` never wraps.
  - `time_left` never underflows.

## Timing
- Latencies, all measured from the edge that samples the input:
  - `my_score`: updates 1 cycle after `duck_hit`.
  - `score_tx_valid`/`score_tx_data`: valid in the same cycle as the new `my_score` value. Pulse width is exactly 1 cycle.
  - `enemy_score`: updates 1 cycle after `enemy_score_valid`.
  - `time_left`: updates 1 cycle after `tick_1s`.
  - `game_over`: rises 1 cycle after the final tick, together with `time_left` = 0. `game_active` falls in that same cycle.
  - `game_active`: rises 1 cycle after `game_start`, together with the cleared scores.
- Input pulses lasting longer than 1 cycle count once per cycle. Upstream logic must supply single-cycle pulses.
- Reset mid-round: all outputs return to their reset values immediately, asynchronously. No `score_tx_valid` pulse is emitted on reset.
- `score_tx_valid` may pulse on consecutive cycles when hits arrive back-to-back. The downstream transmitter must accept one value per cycle or keep only the latest.

## Test plan
- Reset, then `game_start`, then 5 `duck_hit` pulses 3 cycles apart -> `my_score` = 5 and exactly 6 `score_tx_valid` pulses with data 0,1,2,3,4,5. `game_active` = 1.
- MAX_SCORE = 99, 105 hits -> `my_score` stops at 99. Exactly 99 nonzero tx pulses occur and no pulse follows the saturated hits.
- `enemy_score_valid` with 42, then with 120 -> `enemy_score` = 42, then 99. The same strobe sent in IDLE leaves `enemy_score` = 0.
- GAME_SECONDS = 3, three ticks, with a hit in the same cycle as the 3rd tick -> the hit is counted, `time_left` = 0, `game_over` = 1 the following cycle. Later hits and ticks change nothing, and a subsequent enemy strobe of 7 is captured.
- In FINAL, `game_start` together with `duck_hit` -> scores = 0, `time_left` = GAME_SECONDS, one tx pulse with data 0, and the hit is discarded.
- Assert `rst_n` low mid-round with `my_score` = 12 and `time_left` = 20 -> all outputs are 0 before the next clock edge. The block stays in IDLE until `game_start`.
